// File: rtl/nes_clock_sequencer_pkg.sv
// Shared types and default divisors for the NES master-clock sequencer.
// The divisor check is a constant function so that it can gate elaboration.
package nes_clk_pkg;

    localparam int DEFAULT_CPU_DIV = 12;
    localparam int DEFAULT_PPU_DIV = 4;

    typedef enum logic [1:0] {
        HALTED  = 2'd0,
        RUNNING = 2'd1,
        DRAIN   = 2'd2,
        STEP    = 2'd3
    } seq_state_e;

    // A CPU cycle must span at least two master clocks and hold a whole number of dots.
    function automatic bit divisors_ok(input int cpuDiv, input int ppuDiv);
        return (cpuDiv >= 2) && (ppuDiv >= 1) && ((cpuDiv % ppuDiv) == 0);
    endfunction

endpackage

// File: rtl/nes_clock_sequencer_if.sv
// Request pulses in, clock-enable strobes and status out.
// The master side issues requests; the slave side is the sequencer itself.
interface nes_clock_sequencer_if;

    logic        run_req;
    logic        halt_req;
    logic        step_req;
    logic        cpu_ce;
    logic        ppu_ce;
    logic        apu_ce;
    logic        halted;
    logic [31:0] cpu_cycles;

    modport master (
        output run_req, halt_req, step_req,
        input  cpu_ce, ppu_ce, apu_ce, halted, cpu_cycles
    );

    modport slave (
        input  run_req, halt_req, step_req,
        output cpu_ce, ppu_ce, apu_ce, halted, cpu_cycles
    );

endinterface

// File: rtl/nes_clock_sequencer_ce_divider.sv
// Enabled modulo-CPU_DIV master counter with registered CPU/PPU/APU strobe decode.
// Every strobe is produced by an advance, so a frozen counter never emits one.
module nes_ce_divider
    import nes_clk_pkg::*;
#(
    parameter int CPU_DIV = DEFAULT_CPU_DIV,
    parameter int PPU_DIV = DEFAULT_PPU_DIV
) (
    input  logic clk,
    input  logic reset_n,
    input  logic advance_i,
    output logic wrap_o,
    output logic cpu_ce_o,
    output logic ppu_ce_o,
    output logic apu_ce_o
);

    localparam int MW = $clog2(CPU_DIV);
    localparam int PW = (PPU_DIV > 1) ? $clog2(PPU_DIV) : 1;

    logic [MW-1:0] mcnt_q, mcnt_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          apuPh_q;
    logic          cpuCe_q, ppuCe_q, apuCe_q;
    logic          wrap, dotWrap;

    // pcnt tracks mcnt mod PPU_DIV; CPU_DIV being a multiple of PPU_DIV keeps both in step.
    assign wrap    = advance_i && (mcnt_q == MW'(CPU_DIV - 1));
    assign dotWrap = advance_i && (pcnt_q == PW'(PPU_DIV - 1));

    always_comb begin
        mcnt_d = mcnt_q;
        pcnt_d = pcnt_q;
        if (advance_i) begin
            mcnt_d = wrap    ? '0 : mcnt_q + MW'(1);
            pcnt_d = dotWrap ? '0 : pcnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcnt_q  <= '0;
            pcnt_q  <= '0;
            apuPh_q <= 1'b0;
            cpuCe_q <= 1'b0;
            ppuCe_q <= 1'b0;
            apuCe_q <= 1'b0;
        end else begin
            mcnt_q  <= mcnt_d;
            pcnt_q  <= pcnt_d;
            cpuCe_q <= wrap;
            ppuCe_q <= dotWrap;
            apuCe_q <= wrap && apuPh_q;
            if (wrap) begin
                apuPh_q <= ~apuPh_q;
            end
        end
    end

    assign wrap_o   = wrap;
    assign cpu_ce_o = cpuCe_q;
    assign ppu_ce_o = ppuCe_q;
    assign apu_ce_o = apuCe_q;

endmodule

// File: rtl/nes_clock_sequencer.sv
// Run/halt/step sequencer that gates the master divider so every stop lands on a
// CPU-cycle boundary, plus the free-running count of CPU strobes.
module nes_clock_sequencer
    import nes_clk_pkg::*;
#(
    parameter int CPU_DIV   = DEFAULT_CPU_DIV,
    parameter int PPU_DIV   = DEFAULT_PPU_DIV,
    parameter bit RESET_RUN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    nes_clock_sequencer_if.slave  bus
);

    if (!divisors_ok(CPU_DIV, PPU_DIV)) begin : g_bad_divisors
        $error("nes_clock_sequencer: need CPU_DIV >= 2, PPU_DIV >= 1, CPU_DIV %% PPU_DIV == 0");
    end

    seq_state_e  state_q, state_d;
    logic        halted_q, halted_d;
    logic [31:0] cpuCycles_q;
    logic        advance;
    logic        wrap;
    logic        cpuCe, ppuCe, apuCe;

    assign advance = (state_q != HALTED);

    nes_ce_divider #(
        .CPU_DIV (CPU_DIV),
        .PPU_DIV (PPU_DIV)
    ) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .advance_i (advance),
        .wrap_o    (wrap),
        .cpu_ce_o  (cpuCe),
        .ppu_ce_o  (ppuCe),
        .apu_ce_o  (apuCe)
    );

    // Ignored requests simply fall through; the checks are ordered halt > step > run.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HALTED: begin
                if (bus.step_req) begin
                    state_d = STEP;
                end else if (bus.run_req) begin
                    state_d = RUNNING;
                end
            end
            RUNNING: begin
                if (bus.halt_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.run_req && !bus.halt_req) begin
                    state_d = RUNNING;
                end else if (wrap) begin
                    state_d = HALTED;
                end
            end
            STEP: begin
                if (bus.run_req) begin
                    state_d = RUNNING;
                end else if (wrap) begin
                    state_d = HALTED;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // halted trails entry by one cycle so it never overlaps the final cpu_ce of a drain or step.
    assign halted_d = (state_q == HALTED) && (state_d == HALTED);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RESET_RUN ? RUNNING : HALTED;
            halted_q    <= !RESET_RUN;
            cpuCycles_q <= '0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            if (wrap) begin
                cpuCycles_q <= cpuCycles_q + 32'd1;
            end
        end
    end

    assign bus.cpu_ce     = cpuCe;
    assign bus.ppu_ce     = ppuCe;
    assign bus.apu_ce     = apuCe;
    assign bus.halted     = halted_q;
    assign bus.cpu_cycles = cpuCycles_q;

endmodule

// File: tb/tb_nes_clock_sequencer.sv
// Bench for nes_clock_sequencer: directed scenarios with literal expectations plus
// randomized requests checked every cycle against a behavioural model.
module tb_nes_clock_sequencer;
    import nes_clk_pkg::*;

    localparam int CPU_DIV   = 12;
    localparam int PPU_DIV   = 4;
    localparam bit RESET_RUN = 1'b1;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    nes_clock_sequencer_if bus();

    nes_clock_sequencer #(
        .CPU_DIV   (CPU_DIV),
        .PPU_DIV   (PPU_DIV),
        .RESET_RUN (RESET_RUN)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Model: "active" means the master count is moving, "stopPending" means stop at the next boundary.
    bit          mActive      = RESET_RUN;
    bit          mStopPending = 1'b0;
    int          mPos         = 0;
    int          mCeCount     = 0;
    logic [31:0] mCycles      = '0;
    bit          eCpu = 1'b0, ePpu = 1'b0, eApu = 1'b0;
    bit          eHalted      = !RESET_RUN;
    bit          wasActive, atBoundary;

    int          nCpu, nPpu, nApu, nHalted, firstCpu, firstHalted;
    int unsigned pick;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit h, input bit s);
        @(negedge clk);
        bus.run_req  = r;
        bus.halt_req = h;
        bus.step_req = s;
        @(posedge clk);
        #1;
        bus.run_req  = 1'b0;
        bus.halt_req = 1'b0;
        bus.step_req = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mActive      = RESET_RUN;
            mStopPending = 1'b0;
            mPos         = 0;
            mCeCount     = 0;
            mCycles      = '0;
            eCpu         = 1'b0;
            ePpu         = 1'b0;
            eApu         = 1'b0;
            eHalted      = !RESET_RUN;
        end else begin
            wasActive  = mActive;
            atBoundary = (mPos == CPU_DIV - 1);
            eCpu = wasActive && atBoundary;
            ePpu = wasActive && ((mPos % PPU_DIV) == PPU_DIV - 1);
            eApu = eCpu && ((mCeCount % 2) == 1);
            if (eCpu) begin
                mCeCount++;
                mCycles = mCycles + 32'd1;
            end
            if (!wasActive) begin
                if (bus.step_req) begin
                    mActive      = 1'b1;
                    mStopPending = 1'b1;
                end else if (bus.run_req) begin
                    mActive      = 1'b1;
                    mStopPending = 1'b0;
                end
            end else begin
                mPos = (mPos + 1) % CPU_DIV;
                if (bus.halt_req && !mStopPending) begin
                    mStopPending = 1'b1;
                end else if (bus.run_req && !bus.halt_req && mStopPending) begin
                    mStopPending = 1'b0;
                end else if (mStopPending && atBoundary) begin
                    mActive = 1'b0;
                end
            end
            eHalted = !wasActive && !mActive;
        end
    end

    always @(posedge clk) begin
        #1;
        checkOutput("cpu_ce",     {31'd0, bus.cpu_ce}, {31'd0, eCpu});
        checkOutput("ppu_ce",     {31'd0, bus.ppu_ce}, {31'd0, ePpu});
        checkOutput("apu_ce",     {31'd0, bus.apu_ce}, {31'd0, eApu});
        checkOutput("halted",     {31'd0, bus.halted}, {31'd0, eHalted});
        checkOutput("cpu_cycles", bus.cpu_cycles, mCycles);
    end

    initial begin
        bus.run_req  = 1'b0;
        bus.halt_req = 1'b0;
        bus.step_req = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_cpu_ce", {31'd0, bus.cpu_ce}, 32'd0);
        checkOutput("rst_halted", {31'd0, bus.halted}, 32'd0);
        checkOutput("rst_cycles", bus.cpu_cycles, 32'd0);
        reset_n = 1'b1;

        // 48 master clocks of free running after reset
        nCpu = 0; nPpu = 0; nApu = 0;
        for (int i = 0; i < 48; i++) begin
            tick();
            nCpu += int'(bus.cpu_ce);
            nPpu += int'(bus.ppu_ce);
            nApu += int'(bus.apu_ce);
        end
        checkOutput("run48_cpu_ce", nCpu, 4);
        checkOutput("run48_ppu_ce", nPpu, 12);
        checkOutput("run48_apu_ce", nApu, 2);
        checkOutput("run48_cycles", bus.cpu_cycles, 32'd4);

        // halt requested while mcnt == 5
        repeat (5) tick();
        checkOutput("halt_at_mcnt", 32'(dut.u_div.mcnt_q), 32'd5);
        applyStimulus(1'b0, 1'b1, 1'b0);
        nCpu = int'(bus.cpu_ce);
        firstCpu = bus.cpu_ce ? 1 : 0;
        firstHalted = bus.halted ? 1 : 0;
        for (int k = 2; k <= 12; k++) begin
            tick();
            nCpu += int'(bus.cpu_ce);
            if (bus.cpu_ce && firstCpu == 0) firstCpu = k;
            if (bus.halted && firstHalted == 0) firstHalted = k;
        end
        checkOutput("drain_cpu_ce", nCpu, 1);
        checkOutput("drain_ce_edge", firstCpu, 7);
        checkOutput("drain_halt_edge", firstHalted, 8);
        checkOutput("drain_mcnt", 32'(dut.u_div.mcnt_q), 32'd0);
        nCpu = 0; nPpu = 0; nApu = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            nCpu += int'(bus.cpu_ce);
            nPpu += int'(bus.ppu_ce);
            nApu += int'(bus.apu_ce);
        end
        checkOutput("idle_strobes", nCpu + nPpu + nApu, 0);
        checkOutput("idle_cycles", bus.cpu_cycles, 32'd5);

        // single step from halted
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("step_halted_low", {31'd0, bus.halted}, 32'd0);
        nCpu = 0; nPpu = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            nCpu += int'(bus.cpu_ce);
            nPpu += int'(bus.ppu_ce);
        end
        checkOutput("step_cpu_ce", nCpu, 1);
        checkOutput("step_ppu_ce", nPpu, 3);
        checkOutput("step_halted", {31'd0, bus.halted}, 32'd1);
        checkOutput("step_cycles", bus.cpu_cycles, 32'd6);

        // halt+run together enters DRAIN; run at mcnt 3 cancels it
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("hr_state_drain", 32'(dut.state_q), 32'(DRAIN));
        tick();
        tick();
        checkOutput("cancel_mcnt", 32'(dut.u_div.mcnt_q), 32'd3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("cancel_state", 32'(dut.state_q), 32'(RUNNING));
        nCpu = 0; nHalted = 0;
        for (int i = 0; i < 36; i++) begin
            tick();
            nCpu += int'(bus.cpu_ce);
            nHalted += int'(bus.halted);
        end
        checkOutput("cancel_cpu_ce", nCpu, 3);
        checkOutput("cancel_halted", nHalted, 0);

        // cpu_cycles wrap from all-ones
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 40 && !bus.halted; i++) tick();
        checkOutput("wrap_halt_reached", {31'd0, bus.halted}, 32'd1);
        @(negedge clk);
        force dut.cpuCycles_q = 32'hFFFF_FFFF;
        mCycles = 32'hFFFF_FFFF;
        #1;
        release dut.cpuCycles_q;
        tick();
        checkOutput("wrap_preload", bus.cpu_cycles, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (15) tick();
        checkOutput("wrap_cycles", bus.cpu_cycles, 32'd0);

        // reset asserted mid-step at mcnt 7
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (7) tick();
        checkOutput("midstep_mcnt", 32'(dut.u_div.mcnt_q), 32'd7);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("rstmid_cpu_ce", {31'd0, bus.cpu_ce}, 32'd0);
        checkOutput("rstmid_ppu_ce", {31'd0, bus.ppu_ce}, 32'd0);
        checkOutput("rstmid_apu_ce", {31'd0, bus.apu_ce}, 32'd0);
        checkOutput("rstmid_halted", {31'd0, bus.halted}, 32'd0);
        checkOutput("rstmid_cycles", bus.cpu_cycles, 32'd0);
        checkOutput("rstmid_state", 32'(dut.state_q), 32'(RUNNING));
        nCpu = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            nCpu += int'(bus.cpu_ce);
        end
        checkOutput("rstmid_no_ce", nCpu, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // randomized request traffic, checked against the model every cycle
        for (int i = 0; i < 2000; i++) begin
            pick = $urandom_range(0, 15);
            case (pick)
                0:       applyStimulus(1'b1, 1'b0, 1'b0);
                1:       applyStimulus(1'b0, 1'b1, 1'b0);
                2:       applyStimulus(1'b0, 1'b0, 1'b1);
                3:       applyStimulus(1'b1, 1'b0, 1'b1);
                default: applyStimulus(1'b0, 1'b0, 1'b0);
            endcase
        end

        repeat (2) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/nes_clock_sequencer.md
NES_CLOCK_SEQUENCER -- requirements
Module: nes_clock_sequencer

Interface
REQ-001 SHALL have parameter CPU_DIV, default 12, master clocks per CPU cycle.
REQ-002 SHALL have parameter PPU_DIV, default 4, master clocks per PPU dot.
REQ-003 SHALL have parameter RESET_RUN, default 1, selects post-reset state: 1 = RUNNING, 0 = HALTED.
REQ-004 SHALL have port clk  in  1  master clock; single clock domain, all logic on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port run_req  in  1  one-cycle pulse: start or resume free-running.
REQ-007 SHALL have port halt_req  in  1  one-cycle pulse: stop at the next CPU-cycle boundary.
REQ-008 SHALL have port step_req  in  1  one-cycle pulse: execute exactly one CPU cycle from HALTED.
REQ-009 SHALL have port cpu_ce  out  1  CPU clock-enable strobe, one master cycle wide.
REQ-010 SHALL have port ppu_ce  out  1  PPU clock-enable strobe, one master cycle wide.
REQ-011 SHALL have port apu_ce  out  1  APU clock-enable strobe, asserted on every second cpu_ce.
REQ-012 SHALL have port halted  out  1  high while in HALTED.
REQ-013 SHALL have port cpu_cycles  out  32  count of cpu_ce strobes since reset.

Function
REQ-014 SHALL have states HALTED, RUNNING, DRAIN and STEP.
REQ-015 SHALL hold master counter mcnt, width $clog2(CPU_DIV), range 0..CPU_DIV-1; it advances in RUNNING, DRAIN and STEP; it is frozen in HALTED.
REQ-016 SHALL wrap mcnt from CPU_DIV-1 to 0.
REQ-017 SHALL register all strobes; none asserts in a cycle where mcnt is frozen.
- cpu_ce = 1 in the cycle after an advance from mcnt == CPU_DIV-1.
- ppu_ce = 1 in the cycle after an advance from (mcnt mod PPU_DIV) == PPU_DIV-1.
REQ-018 SHALL assert apu_ce together with cpu_ce when internal toggle apu_ph == 1, then invert apu_ph on every cpu_ce.
REQ-019 SHALL increment cpu_cycles on every cpu_ce, wrapping modulo 2^32.
REQ-020 SHALL use these transitions:
- HALTED + run_req -> RUNNING.
- HALTED + step_req -> STEP.
- RUNNING + halt_req -> DRAIN.
- DRAIN + run_req -> RUNNING (halt cancelled).
- DRAIN -> HALTED on the advance from mcnt == CPU_DIV-1.
- STEP -> HALTED on the advance from mcnt == CPU_DIV-1.
- STEP + run_req -> RUNNING.
REQ-021 SHALL apply simultaneous-request priority halt_req > step_req > run_req.
REQ-022 SHALL ignore step_req outside HALTED, halt_req in HALTED or STEP, and run_req in RUNNING.
REQ-023 SHALL always leave HALTED with mcnt == 0, so every halt lands on a CPU-cycle boundary.
REQ-024 SHALL give exactly 1 cpu_ce and CPU_DIV/PPU_DIV ppu_ce per STEP.
REQ-025 SHALL bound DRAIN to at most CPU_DIV master cycles.
REQ-026 SHALL raise halted in the cycle after the final cpu_ce of a DRAIN or STEP.
REQ-027 SHALL fail elaboration unless CPU_DIV >= 2, PPU_DIV >= 1 and CPU_DIV mod PPU_DIV == 0.

Reset
REQ-028 SHALL, while reset_n is low, force asynchronously: mcnt = 0, apu_ph = 0, cpu_ce = ppu_ce = apu_ce = 0, cpu_cycles = 0, state = RUNNING if RESET_RUN else HALTED.
REQ-029 SHALL set halted = !RESET_RUN during reset.
REQ-030 SHALL leave any DRAIN or STEP in progress abandoned, with no partial strobe, when reset asserts mid-operation.
REQ-031 SHALL start counting on the first rising clk edge after reset_n deasserts.

Structure
REQ-032 SHALL place the state enum and default divisor constants (CPU_DIV = 12, PPU_DIV = 4) in shared package nes_clk_pkg.
REQ-033 SHALL implement the enabled modulo counter plus strobe decode as one sub-module, nes_ce_divider; sequencing stays in the top module.

Verification
REQ-034 Reset with RESET_RUN = 1, 48 master cycles -> 4 cpu_ce, 12 ppu_ce, 2 apu_ce, cpu_cycles = 4.
REQ-035 halt_req at mcnt = 5 -> exactly 6 more advances, one cpu_ce, halted = 1 next cycle, mcnt = 0; strobes stay silent for 100 cycles.
REQ-036 From HALTED, step_req -> 12 advances, 1 cpu_ce, 3 ppu_ce, back to HALTED; cpu_cycles +1.
REQ-037 Same-cycle halt_req + run_req in RUNNING -> DRAIN; run_req during DRAIN at mcnt = 3 -> RUNNING, no halt.
REQ-038 reset_n low mid-STEP at mcnt = 7 -> all outputs 0 immediately, no cpu_ce; state follows RESET_RUN.
REQ-039 cpu_cycles preloaded near 2^32-1 via force -> wraps to 0 on the next cpu_ce.
